// File: rtl/tipi_rdmux_pkg.sv
// Shared types and helpers for the TI host register read-back mux.
package tipi_rdmux_pkg;

  localparam int unsigned MAX_CHANNELS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Lowest set bit wins; returns 0 when nothing is set (caller checks |sel)
  function automatic int unsigned prio_idx(input logic [MAX_CHANNELS-1:0] sel);
    prio_idx = 0;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (sel[i]) prio_idx = unsigned'(i);
    end
  endfunction

  function automatic logic [MAX_CHANNELS-1:0] onehot(input int unsigned idx,
                                                     input int unsigned channels);
    onehot = '0;
    for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
      onehot[i] = (i == idx) && (i < channels);
    end
  endfunction

endpackage

// File: rtl/tipi_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module tipi_sync2 #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tipi_rd_mux.sv
// Registered priority read-back mux for host register reads.
// Define TIPI_RDMUX_SYNC_EN to pass rd_en/sel through 2-flop synchronizers.
module tipi_rd_mux
  import tipi_rdmux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic [CHANNELS-1:0]       rd_ack,
  output logic                      rd_miss
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                rd_s;
  logic [CHANNELS-1:0] sel_s;

`ifdef TIPI_RDMUX_SYNC_EN
  // rd sync resets high so a strobe already high at reset release is not a rise
  tipi_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_en),
    .q     (rd_s)
  );

  tipi_sync2 #(.WIDTH(CHANNELS), .RST_VAL('0)) u_sync_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sel),
    .q     (sel_s)
  );
`else
  assign rd_s  = rd_en;
  assign sel_s = sel;
`endif

  logic [WIDTH-1:0] din_a [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_din
    assign din_a[g] = din[g*WIDTH +: WIDTH];
  end

  logic [IDX_W-1:0]        idx;
  logic [MAX_CHANNELS-1:0] ack_full;

  assign idx      = IDX_W'(prio_idx(MAX_CHANNELS'(sel_s)));
  assign ack_full = onehot(32'(idx), CHANNELS);

  state_t              state, state_n;
  logic                rd_q;
  logic [WIDTH-1:0]    dout_n;
  logic                valid_n;
  logic [CHANNELS-1:0] ack_n;
  logic                miss_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_q       <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
      rd_ack     <= '0;
      rd_miss    <= 1'b0;
    end else begin
      state      <= state_n;
      rd_q       <= rd_s;
      dout       <= dout_n;
      dout_valid <= valid_n;
      rd_ack     <= ack_n;
      rd_miss    <= miss_n;
    end
  end

  // Capture on rd rise in IDLE; freeze in HOLD until rd drops
  always_comb begin
    state_n = state;
    dout_n  = dout;
    valid_n = dout_valid;
    ack_n   = '0;
    miss_n  = 1'b0;
    case (state)
      IDLE: begin
        dout_n  = '0;
        valid_n = 1'b0;
        if (rd_s && !rd_q) begin
          state_n = HOLD;
          valid_n = 1'b1;
          if (|sel_s) begin
            dout_n = din_a[idx];
            ack_n  = ack_full[CHANNELS-1:0];
          end else begin
            miss_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!rd_s) begin
          state_n = IDLE;
          dout_n  = '0;
          valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tipi_rd_mux.sv
// Scoreboard bench for tipi_rd_mux (CHANNELS=4, WIDTH=8).
module tb_tipi_rd_mux;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
`ifdef TIPI_RDMUX_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic [CH-1:0]     sel = '0;
  logic [CH*W-1:0]   din = 32'h44332211;
  logic [W-1:0]      dout;
  logic              dout_valid;
  logic [CH-1:0]     rd_ack;
  logic              rd_miss;

  tipi_rd_mux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .sel        (sel),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .rd_ack     (rd_ack),
    .rd_miss    (rd_miss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  dout;
    logic [CH-1:0] ack;
    logic          miss;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pop on each new capture, otherwise enforce hold/idle invariants
  initial begin
    logic       prev_valid;
    logic [W-1:0] held;
    exp_t       e;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (dout_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_capture: got dout=%0h ack=%b miss=%b, required none", dout, rd_ack, rd_miss);
        end else begin
          e = exp_q.pop_front();
          chk("cap_dout", 32'(dout), 32'(e.dout));
          chk("cap_ack", 32'(rd_ack), 32'(e.ack));
          chk("cap_miss", 32'(rd_miss), 32'(e.miss));
          held = e.dout;
        end
      end else begin
        chk("no_pulse", 32'({rd_ack, rd_miss}), 32'd0);
        if (dout_valid) chk("hold_dout", 32'(dout), 32'(held));
        else            chk("idle_dout", 32'(dout), 32'd0);
      end
      prev_valid = dout_valid;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise rd with sel applied, expect capture LAT clocks later
  task automatic read_rise(input logic [CH-1:0] s, input logic [W-1:0] d,
                           input logic [CH-1:0] a, input logic m);
    exp_t e;
    e.dout = d; e.ack = a; e.miss = m;
    exp_q.push_back(e);
    sel   = s;
    rd_en = 1'b1;
    tick(LAT);
    chk("lat_valid", 32'(dout_valid), 32'd1);
    chk("lat_ack", 32'(rd_ack), 32'(a));
    tick(1);
    chk("ack_one_cycle", 32'({rd_ack, rd_miss}), 32'd0);
  endtask

  task automatic read_fall();
    rd_en = 1'b0;
    tick(LAT);
    chk("fall_valid", 32'(dout_valid), 32'd0);
    chk("fall_dout", 32'(dout), 32'd0);
  endtask

  initial begin
    tick(2);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_pulses", 32'({rd_ack, rd_miss}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: single sel bit
    read_rise(4'b0100, 8'h33, 4'b0100, 1'b0);
    read_fall();

    // 2/3: multi-hot priority, long hold, input changes ignored
    read_rise(4'b1010, 8'h22, 4'b0010, 1'b0);
    tick(8);
    sel = 4'b0001;
    din[15:8] = 8'hFF;
    tick(3);
    chk("hold_after_change", 32'(dout), 32'h22);
    read_fall();
    din = 32'h44332211;

    // 4: miss
    read_rise(4'b0000, 8'h00, 4'b0000, 1'b1);
    read_fall();

    // Priority boundaries: all set, only top channel
    read_rise(4'b1111, 8'h11, 4'b0001, 1'b0);
    read_fall();
    read_rise(4'b1000, 8'h44, 4'b1000, 1'b0);
    // rd low for exactly one cycle re-arms
    rd_en = 1'b0;
    tick(1);
    read_rise(4'b0010, 8'h22, 4'b0010, 1'b0);
    read_fall();

    // 5: reset mid-HOLD with rd held high
    read_rise(4'b0001, 8'h11, 4'b0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(LAT + 4);
    chk("no_recapture_valid", 32'(dout_valid), 32'd0);
    rd_en = 1'b0;
    tick(LAT);
    read_rise(4'b0001, 8'h11, 4'b0001, 1'b0);
    read_fall();

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
